// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the writeback trace buffer:
//   - trigger FSM state encodings
//   - entry field widths and bit offsets within a packed RAM entry
//   - helper to derive the packed entry width
// Optional feature macro: TRACE_TIMESTAMP_EN adds a TS_W-bit timestamp field
// at the top of each entry.
// -----------------------------------------------------------------------------
package trace_pkg;

    // Trigger FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_POST   = 2'd2;
    localparam logic [1:0] ST_FROZEN = 2'd3;

    // Field widths that do not depend on XLEN
    localparam int RD_W = 5;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_EN = 1;
`else
    localparam int TS_EN = 0;
`endif

    // Packed entry layout, LSB first: data | rd | pc | [ts]
    localparam int DATA_LSB = 0;

    function automatic int rd_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int pc_lsb(input int xlen);
        return xlen + RD_W;
    endfunction

    function automatic int ts_lsb(input int xlen);
        return 2 * xlen + RD_W;
    endfunction

    // XLEN + 5 + XLEN, plus TS_W when timestamps are compiled in
    function automatic int entry_w(input int xlen, input int ts_w);
        return 2 * xlen + RD_W + TS_EN * ts_w;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer_if
// Bundles the writeback feed and the FWFT read port of the trace buffer.
//   writeback : wb_reg_write, wb_rd, wb_data, wb_pc   (producer -> buffer)
//   read port : rd_valid, rd_pc, rd_rd, rd_data[, rd_ts] (buffer -> consumer)
//               rd_ready                               (consumer -> buffer)
// modport slave  : the trace buffer side
// modport master : the CPU / debug consumer side
// Optional feature macro: TRACE_TIMESTAMP_EN adds rd_ts and the TS_W parameter.
// -----------------------------------------------------------------------------
interface wb_trace_buffer_if #(
    parameter int XLEN = 32
`ifdef TRACE_TIMESTAMP_EN
   ,parameter int TS_W = 16
`endif
);
    // Writeback feed
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] wb_pc;

    // Read port
    logic            rd_valid;
    logic            rd_ready;
    logic [XLEN-1:0] rd_pc;
    logic [4:0]      rd_rd;
    logic [XLEN-1:0] rd_data;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] rd_ts;
`endif

    modport slave (
        input  wb_reg_write, wb_rd, wb_data, wb_pc, rd_ready,
        output rd_valid, rd_pc, rd_rd, rd_data
`ifdef TRACE_TIMESTAMP_EN
       ,output rd_ts
`endif
    );

    modport master (
        output wb_reg_write, wb_rd, wb_data, wb_pc, rd_ready,
        input  rd_valid, rd_pc, rd_rd, rd_data
`ifdef TRACE_TIMESTAMP_EN
       ,input  rd_ts
`endif
    );

endinterface

// File: rtl/trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
// DEPTH x WIDTH entry storage: one synchronous write port, one asynchronous
// (combinational) read port so the buffer can present its head entry FWFT.
// Ports:
//   clk   in            write clock
//   we    in            write enable
//   waddr in  AW        write address
//   wdata in  WIDTH     write data
//   raddr in  AW        read address
//   rdata out WIDTH     read data, combinational from raddr
// -----------------------------------------------------------------------------
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 69,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never visible and the array
    // can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
// On-chip commit trace for the RV32I pipeline. Each architectural register
// writeback (rd != x0) is stored as (pc, rd, data) in a circular buffer.
// A masked match trigger plus a post-trigger count freezes capture; entries
// are read out through an FWFT valid/ready port.
// Ports:
//   clk        in         system clock, rising edge
//   reset      in         asynchronous, active-high reset
//   clear      in         synchronous flush of buffer, flags and trigger state
//   cap_en     in         capture enable
//   mode_wrap  in         1 = overwrite oldest when full, 0 = drop new
//   bus        slave      writeback feed and read port (wb_trace_buffer_if)
//   trig_arm   in         pulse: clear triggered and arm the trigger
//   trig_rd    in  5      trigger register index
//   trig_data  in  XLEN   trigger compare value
//   trig_mask  in  XLEN   compare mask, 1 = bit compared
//   count      out AW+1   occupancy 0..DEPTH
//   overflow   out        sticky: at least one entry lost
//   triggered  out        sticky: trigger has fired
//   frozen     out        capture stopped
// Optional feature macro: TRACE_TIMESTAMP_EN stores a free-running TS_W-bit
// cycle count with each entry and presents it on bus.rd_ts.
// -----------------------------------------------------------------------------
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4,
    parameter int TS_W      = 16,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              cap_en,
    input  logic              mode_wrap,
    wb_trace_buffer_if.slave  bus,
    input  logic              trig_arm,
    input  logic [4:0]        trig_rd,
    input  logic [XLEN-1:0]   trig_data,
    input  logic [XLEN-1:0]   trig_mask,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              triggered,
    output logic              frozen
);

    localparam int             EW        = entry_w(XLEN, TS_W);
    localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  POST_INIT = AW'(POST_TRIG);

    // State
    logic [1:0]    state_q,     state_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [AW-1:0] post_cnt_q,  post_cnt_d;
    logic [AW:0]   count_q,     count_d;
    logic          overflow_q,  overflow_d;
    logic          triggered_q, triggered_d;

    // Per-cycle decode
    logic          capture;
    logic          full;
    logic          pop;
    logic          push;
    logic          trig_match;

    // RAM interface
    logic          ram_we;
    logic [EW-1:0] ram_wdata;
    logic [EW-1:0] ram_rdata;

    // -------------------------------------------------------------------------
    // Optional timestamp: free-running, ignores clear, wraps silently
    // -------------------------------------------------------------------------
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    assign ts_d = ts_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign ram_wdata = {ts_q, bus.wb_pc, bus.wb_rd, bus.wb_data};
    assign bus.rd_ts = ram_rdata[ts_lsb(XLEN) +: TS_W];
`else
    assign ram_wdata = {bus.wb_pc, bus.wb_rd, bus.wb_data};
`endif

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    assign capture    = bus.wb_reg_write && (bus.wb_rd != 5'd0) && cap_en
                        && (state_q != ST_FROZEN);
    assign full       = (count_q == FULL_CNT);
    assign pop        = (count_q != '0) && bus.rd_ready;
    // A full buffer still accepts a capture when the same-cycle pop frees a
    // slot, or in wrap mode by evicting the head entry.
    assign push       = capture && (!full || pop || mode_wrap);
    assign trig_match = (bus.wb_rd == trig_rd)
                        && (((bus.wb_data ^ trig_data) & trig_mask) == '0);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the branches below can infer a latch.
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        post_cnt_d  = post_cnt_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q;
        ram_we      = 1'b0;

        if (clear) begin
            // Flush wins over arm, push and pop in the same cycle
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            post_cnt_d  = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
        end else begin
            ram_we = push;

            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end

            // Head moves on a pop, or when a wrap-mode push evicts it
            if (pop || (push && full)) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            if (push && !pop && !full) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end

            // Lost entry: either dropped or overwritten
            if (capture && full && !pop) begin
                overflow_d = 1'b1;
            end

            case (state_q)
                ST_ARMED: begin
                    if (capture && trig_match) begin
                        triggered_d = 1'b1;
                        if (POST_INIT == '0) begin
                            state_d = ST_FROZEN;
                        end else begin
                            state_d    = ST_POST;
                            post_cnt_d = POST_INIT;
                        end
                    end
                end
                ST_POST: begin
                    // The event that takes the counter to zero is still captured
                    if (capture) begin
                        post_cnt_d = post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) begin
                            state_d = ST_FROZEN;
                        end
                    end
                end
                default: ;
            endcase

            // Re-arming is allowed from any state and keeps buffer contents
            if (trig_arm) begin
                triggered_d = 1'b0;
                state_d     = ST_ARMED;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            post_cnt_q  <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            post_cnt_q  <= post_cnt_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (ram_wdata),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.rd_valid = (count_q != '0);
    assign bus.rd_data  = ram_rdata[DATA_LSB +: XLEN];
    assign bus.rd_rd    = ram_rdata[rd_lsb(XLEN) +: RD_W];
    assign bus.rd_pc    = ram_rdata[pc_lsb(XLEN) +: XLEN];

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign triggered = triggered_q;
    assign frozen    = (state_q == ST_FROZEN);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_trace_buffer
// Directed bench for wb_trace_buffer. Each captured writeback pushes its
// expected entry into a scoreboard queue; a monitor pops and compares every
// time the read handshake completes. Flags and occupancy are checked inline.
// Optional feature macro: TRACE_TIMESTAMP_EN enables the timestamp section.
// -----------------------------------------------------------------------------
module tb_wb_trace_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        cap_en;
    logic        mode_wrap;
    logic        trig_arm;
    logic [4:0]  trig_rd;
    logic [31:0] trig_data;
    logic [31:0] trig_mask;
    logic [4:0]  count;
    logic        overflow;
    logic        triggered;
    logic        frozen;

    int vectors     = 0;
    int miscompares = 0;

    entry_t sb[$];

    wb_trace_buffer_if #(.XLEN(32)) bus ();

    wb_trace_buffer #(
        .XLEN      (32),
        .DEPTH     (16),
        .POST_TRIG (4),
        .TS_W      (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .cap_en    (cap_en),
        .mode_wrap (mode_wrap),
        .bus       (bus),
        .trig_arm  (trig_arm),
        .trig_rd   (trig_rd),
        .trig_data (trig_data),
        .trig_mask (trig_mask),
        .count     (count),
        .overflow  (overflow),
        .triggered (triggered),
        .frozen    (frozen)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data,
                          input bit stored, input bit evict);
        bus.wb_reg_write = 1'b1;
        bus.wb_pc        = pc;
        bus.wb_rd        = rd;
        bus.wb_data      = data;
        if (evict) sb.delete(0);
        if (stored) sb.push_back({pc, rd, data});
        tick();
        bus.wb_reg_write = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
    endtask

    task automatic do_arm(input logic [4:0] r, input logic [31:0] d, input logic [31:0] m);
        trig_rd   = r;
        trig_data = d;
        trig_mask = m;
        trig_arm  = 1'b1;
        tick();
        trig_arm  = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        bus.rd_ready = 1'b1;
        while (bus.rd_valid && guard < 40) begin
            tick();
            guard++;
        end
        bus.rd_ready = 1'b0;
        check("drain_done", {31'd0, bus.rd_valid}, 32'd0);
        check("scoreboard_empty", sb.size(), 32'd0);
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        entry_t e;
        if (!reset && !clear && bus.rd_valid && bus.rd_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got pc=%0h rd=%0d data=%0h, required no entry",
                         bus.rd_pc, bus.rd_rd, bus.rd_data);
            end else begin
                e = sb.pop_front();
                if (bus.rd_pc !== e.pc || bus.rd_rd !== e.rd || bus.rd_data !== e.data) begin
                    miscompares++;
                    $display("FAIL pop_entry: got pc=%0h rd=%0d data=%0h, required pc=%0h rd=%0d data=%0h",
                             bus.rd_pc, bus.rd_rd, bus.rd_data, e.pc, e.rd, e.data);
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        reset            = 1'b1;
        clear            = 1'b0;
        cap_en           = 1'b0;
        mode_wrap        = 1'b0;
        trig_arm         = 1'b0;
        trig_rd          = '0;
        trig_data        = '0;
        trig_mask        = '0;
        bus.wb_reg_write = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_data      = '0;
        bus.wb_pc        = '0;
        bus.rd_ready     = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("reset_count", count, 32'd0);
        check("reset_valid", bus.rd_valid, 32'd0);
        check("reset_overflow", overflow, 32'd0);
        check("reset_triggered", triggered, 32'd0);
        check("reset_frozen", frozen, 32'd0);

        cap_en = 1'b1;

        // Basic capture; x0 write is never stored
        retire(32'h00, 5'd1, 32'h5, 1'b1, 1'b0);
        retire(32'h04, 5'd0, 32'h9, 1'b0, 1'b0);
        retire(32'h08, 5'd2, 32'hA, 1'b1, 1'b0);
        check("basic_count", count, 32'd2);
        check("basic_head_pc", bus.rd_pc, 32'h00);
        drain();
        check("basic_count_empty", count, 32'd0);

        // Drop mode: 17 captures, 17th lost
        mode_wrap = 1'b0;
        for (int i = 0; i < 17; i++)
            retire(32'h100 + 32'(4 * i), 5'((i % 31) + 1), 32'(i + 1), i < 16, 1'b0);
        check("drop_count", count, 32'd16);
        check("drop_overflow", overflow, 32'd1);
        check("drop_head_data", bus.rd_data, 32'd1);
        drain();
        do_clear();
        check("clear_overflow", overflow, 32'd0);

        // Wrap mode: 17 captures, first entry overwritten
        mode_wrap = 1'b1;
        for (int i = 0; i < 17; i++)
            retire(32'h100 + 32'(4 * i), 5'((i % 31) + 1), 32'(i + 1), 1'b1, i == 16);
        check("wrap_count", count, 32'd16);
        check("wrap_overflow", overflow, 32'd1);
        check("wrap_head_pc", bus.rd_pc, 32'h104);
        drain();
        do_clear();
        mode_wrap = 1'b0;

        // Trigger with POST_TRIG = 4
        do_arm(5'd5, 32'h100, 32'hFFF);
        retire(32'h400, 5'd5, 32'h200, 1'b1, 1'b0);
        check("trig_nomatch", triggered, 32'd0);
        retire(32'h404, 5'd5, 32'hABC100, 1'b1, 1'b0);
        check("trig_fired", triggered, 32'd1);
        for (int i = 0; i < 3; i++)
            retire(32'h408 + 32'(4 * i), 5'd3, 32'(i), 1'b1, 1'b0);
        check("post3_not_frozen", frozen, 32'd0);
        retire(32'h414, 5'd3, 32'h33, 1'b1, 1'b0);
        check("post4_frozen", frozen, 32'd1);
        check("frozen_count", count, 32'd6);
        retire(32'h418, 5'd4, 32'h44, 1'b0, 1'b0);
        check("frozen_count_held", count, 32'd6);
        do_arm(5'd5, 32'h100, 32'hFFF);
        check("rearm_frozen", frozen, 32'd0);
        check("rearm_triggered", triggered, 32'd0);
        check("rearm_count", count, 32'd6);
        drain();
        do_clear();

        // Full buffer with simultaneous push and pop
        for (int i = 0; i < 16; i++)
            retire(32'h200 + 32'(4 * i), 5'd7, 32'(i), 1'b1, 1'b0);
        check("full_count", count, 32'd16);
        bus.rd_ready = 1'b1;
        retire(32'h300, 5'd7, 32'h99, 1'b1, 1'b0);
        bus.rd_ready = 1'b0;
        check("pushpop_count", count, 32'd16);
        check("pushpop_overflow", overflow, 32'd0);

        // Clear beats a same-cycle push
        clear            = 1'b1;
        bus.wb_reg_write = 1'b1;
        bus.wb_rd        = 5'd7;
        bus.wb_data      = 32'h77;
        tick();
        clear            = 1'b0;
        bus.wb_reg_write = 1'b0;
        sb.delete();
        check("clear_push_count", count, 32'd0);
        check("clear_push_valid", bus.rd_valid, 32'd0);

        // Asynchronous reset while in POST with 7 entries
        do_arm(5'd5, 32'h100, 32'hFFF);
        for (int i = 0; i < 6; i++)
            retire(32'h500 + 32'(4 * i), 5'd6, 32'(i), 1'b1, 1'b0);
        retire(32'h518, 5'd5, 32'hABC100, 1'b1, 1'b0);
        check("post_count", count, 32'd7);
        check("post_triggered", triggered, 32'd1);
        #2 reset = 1'b1;
        #1;
        sb.delete();
        check("async_count", count, 32'd0);
        check("async_valid", bus.rd_valid, 32'd0);
        check("async_overflow", overflow, 32'd0);
        check("async_triggered", triggered, 32'd0);
        check("async_frozen", frozen, 32'd0);
        tick();
        reset = 1'b0;
        retire(32'h600, 5'd9, 32'hBEEF, 1'b1, 1'b0);
        check("after_reset_count", count, 32'd1);
        drain();

`ifdef TRACE_TIMESTAMP_EN
        begin
            logic [15:0] ts_a;
            logic [15:0] ts_diff;
            do_clear();
            retire(32'h700, 5'd10, 32'h1, 1'b1, 1'b0);
            tick();
            tick();
            retire(32'h704, 5'd11, 32'h2, 1'b1, 1'b0);
            ts_a = bus.rd_ts;
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
            ts_diff = bus.rd_ts - ts_a;
            check("ts_delta", 32'(ts_diff), 32'd3);
            drain();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Hardware commit-trace capture for the 5-stage RV32I pipeline. Replaces console monitoring of the writeback debug signals with an on-chip circular buffer.
- Records each architectural register writeback as an entry (pc, rd, data). A match trigger with post-trigger count freezes capture; a valid/ready port reads entries out.
- Sits beside cpu_top and is fed from the dbg_wb_* signals plus the PC of the retiring instruction.

Parameters:
- XLEN, 32, datapath width of pc and data fields.
- DEPTH, 16, number of entries; power of two, >= 2. AW = log2(DEPTH) is derived.
- POST_TRIG, 4, entries captured after the triggering entry before freezing; 0..DEPTH-1.
- TS_W, 16, timestamp width; used only when TRACE_TIMESTAMP_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of buffer, flags and trigger state.
- cap_en  in  1  capture enable.
- mode_wrap  in  1  1 = overwrite oldest entry when full; 0 = drop new entries when full.
- wb_reg_write  in  1  writeback write enable.
- wb_rd  in  5  writeback destination register.
- wb_data  in  XLEN  writeback value.
- wb_pc  in  XLEN  PC of the retiring instruction.
- trig_arm  in  1  single-cycle pulse that arms the trigger.
- trig_rd  in  5  trigger register index.
- trig_data  in  XLEN  trigger compare value.
- trig_mask  in  XLEN  compare mask; 1 = bit compared.
- rd_valid  out  1  oldest entry is available.
- rd_ready  in  1  consumer accepts the entry.
- rd_pc  out  XLEN  oldest entry, pc field.
- rd_rd  out  5  oldest entry, rd field.
- rd_data  out  XLEN  oldest entry, data field.
- count  out  AW+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: at least one entry lost.
- triggered  out  1  sticky flag: trigger has fired.
- frozen  out  1  capture stopped.

Behaviour:
- Reset: all outputs 0, pointers 0, state IDLE, post counter 0.
- Capture event = wb_reg_write && wb_rd != 0 && cap_en && state != FROZEN. Writes to x0 are never captured.
- Event at clk edge N: entry readable from cycle N+1; count updates at the same edge.
- Read port is FWFT. rd_valid = (count != 0). rd_* show the head entry via combinational read. A pop occurs when rd_valid && rd_ready.
- Push + pop, not full: count unchanged, both pointers advance.
- Push + pop, full: the pop frees a slot and the push fills it. count stays DEPTH; no overflow.
- Push without pop, full, mode_wrap=1: oldest entry is overwritten, head advances, overflow is set.
- Push without pop, full, mode_wrap=0: push is dropped, overflow is set.
- Overwrite while rd_valid && !rd_ready: rd_* may change. The consumer must sample only on the handshake.
- Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: captures, no compare. trig_arm -> ARMED.
  - ARMED: compare on each capture event: wb_rd == trig_rd && (wb_data & trig_mask) == (trig_data & trig_mask). On a match the entry is captured and triggered is set. Next state is POST with counter = POST_TRIG, or FROZEN if POST_TRIG == 0.
  - POST: each capture event decrements the counter. The event that decrements it to 0 is captured, then state -> FROZEN.
  - FROZEN: no capture; frozen = 1; reads continue normally.
- trig_arm in any state: clears triggered, state -> ARMED. Buffer contents are kept.
- clear: empties buffer (count 0), clears overflow and triggered, state -> IDLE.
- clear has priority over trig_arm, push and pop in the same cycle.
- A reset asserted mid-operation returns everything to reset values immediately. No partial entry survives.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W-bit cycle counter is included. It resets to 0, ignores clear, and wraps silently.
  - The counter is stored with each entry and presented on an extra output rd_ts (out, TS_W).
- Undefined: no counter, no rd_ts port, and no added storage.

Decomposition:
- Shared package/header trace_pkg holds:
  - state encodings (IDLE = 0, ARMED = 1, POST = 2, FROZEN = 3);
  - entry field widths and offsets;
  - derived entry width (XLEN + 5 + XLEN [+ TS_W]).
- Sub-module trace_ram: DEPTH x entry-width storage with one synchronous write port and one asynchronous read port.
- Pointer, count, flag and FSM logic stay in wb_trace_buffer.

Test Plan:
- Retire writes (pc 0x00,rd 1,0x5), (0x04,x0,0x9), (0x08,rd 2,0xA) with rd_ready=0 -> count=2; pop yields (0x00,1,0x5) then (0x08,2,0xA); x0 write absent.
- DEPTH=16, mode_wrap=0, 17 captures, no pops -> count=16, overflow=1; entries hold captures 1..16.
- DEPTH=16, mode_wrap=1, 17 captures, no pops -> count=16, overflow=1; first pop returns capture 2.
- Arm with trig_rd=5, trig_data=0x100, trig_mask=0xFFF; POST_TRIG=4; write rd 5 = 0xABC100 -> triggered=1. After 4 further captures frozen=1 and count stops. Arm again -> frozen=0, triggered=0, count kept.
- Full buffer with push + pop in the same cycle -> count stays 16, overflow stays 0. Same-cycle clear + push -> count=0.
- Assert reset during POST with count=7 -> count=0, all flags 0, rd_valid=0. With TRACE_TIMESTAMP_EN, captures 3 cycles apart -> rd_ts differs by 3.
